// File: rtl/stopwatch_lap_if.sv
// rtl/stopwatch_lap_if.sv - button inputs and display/status outputs of the lap stopwatch
//
// Purpose: groups the stopwatch's button inputs and display/status outputs.
// Signals:
//   start_stop, lap, quick          : level inputs (buttons, quick-tick select)
//   seg_c1 .. seg_m10 [6:0]         : digit patterns {g,f,e,d,c,b,a}
//   running, lap_active, ovf        : status flags
// Modports: master drives the inputs, slave is the stopwatch itself.
interface stopwatch_lap_if;
  logic       start_stop;
  logic       lap;
  logic       quick;
  logic [6:0] seg_c1;
  logic [6:0] seg_c10;
  logic [6:0] seg_s1;
  logic [6:0] seg_s10;
  logic [6:0] seg_m1;
  logic [6:0] seg_m10;
  logic       running;
  logic       lap_active;
  logic       ovf;

  modport master (
    output start_stop, lap, quick,
    input  seg_c1, seg_c10, seg_s1, seg_s10, seg_m1, seg_m10,
    input  running, lap_active, ovf
  );

  modport slave (
    input  start_stop, lap, quick,
    output seg_c1, seg_c10, seg_s1, seg_s10, seg_m1, seg_m10,
    output running, lap_active, ovf
  );
endinterface

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - mm:ss.cc BCD stopwatch with lap hold, clear, quick mode and saturation
//
// Purpose: counts hundredths of a second in BCD up to 99:59.99 under control of
// a four-state FSM (IDLE, RUN, LAP, STOP) and drives six registered 7-seg digits.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   sw  : stopwatch_lap_if.slave (buttons in, digits and status out)
module stopwatch_lap #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 100,
  parameter int QUICK_MULT     = 100,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_lap_if.slave  sw
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int QDIV = DIV / QUICK_MULT;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAP  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  // Count layout {m10, m1, s10, s1, c10, c1}, one BCD nibble each.
  localparam logic [23:0] CNT_MAX  = 24'h995999;
  localparam logic [6:0]  SEG_ZERO = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  top;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      top = (i == 3) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] == top) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Bits [1:0] synchronise; bit [2] is the previous synchronised level for edge detection.
  logic [2:0]    ss_sync_q, lap_sync_q;
  logic [1:0]    quick_sync_q;
  logic          ss_p, lap_p;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [23:0]   split_q, split_d;
  logic          ovf_q, ovf_d;
  logic [41:0]   seg_q, seg_d;

  logic          counting, tick, at_max, clear;
  logic [31:0]   div_lim_m1;
  logic [23:0]   disp;

  assign ss_p  = ss_sync_q[1]  & ~ss_sync_q[2];
  assign lap_p = lap_sync_q[1] & ~lap_sync_q[2];

  assign counting   = (state_q == ST_RUN) || (state_q == ST_LAP);
  // >= rather than == so that shrinking the limit mid-run ticks immediately.
  assign div_lim_m1 = quick_sync_q[1] ? 32'(QDIV - 1) : 32'(DIV - 1);
  assign tick       = counting && (32'(div_q) >= div_lim_m1);
  assign at_max     = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    split_d = split_q;
    ovf_d   = ovf_q;
    clear   = 1'b0;

    if (tick) begin
      if (at_max) ovf_d = 1'b1;
      else        cnt_d = bcd_inc(cnt_q);
    end

    // ss_p is checked first in every state, so a simultaneous lap_p is dropped.
    case (state_q)
      ST_IDLE: if (ss_p) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_p) state_d = ST_STOP;
        else if (lap_p) begin
          state_d = ST_LAP;
          split_d = cnt_q;
        end
      end
      ST_LAP: begin
        if (ss_p)       state_d = ST_STOP;
        else if (lap_p) state_d = ST_RUN;
      end
      default: begin
        if (ss_p) begin
          if (!ovf_q) state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase

    // Saturation overrides any button action taken while counting.
    if (tick && at_max) state_d = ST_STOP;
  end

  always_comb begin
    div_d = div_q;
    if (clear || (state_q == ST_IDLE)) div_d = '0;
    else if (tick)                     div_d = '0;
    else if (counting)                 div_d = div_q + DW'(1);
  end

  assign disp  = (state_q == ST_LAP) ? split_q : cnt_q;
  assign seg_d = {seg_dec(disp[23:20]), seg_dec(disp[19:16]), seg_dec(disp[15:12]),
                  seg_dec(disp[11:8]),  seg_dec(disp[7:4]),   seg_dec(disp[3:0])};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync_q    <= '0;
      lap_sync_q   <= '0;
      quick_sync_q <= '0;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      split_q      <= '0;
      ovf_q        <= 1'b0;
      seg_q        <= {6{SEG_ZERO}};
    end else begin
      ss_sync_q    <= {ss_sync_q[1:0],  sw.start_stop};
      lap_sync_q   <= {lap_sync_q[1:0], sw.lap};
      quick_sync_q <= {quick_sync_q[0], sw.quick};
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      split_q      <= split_d;
      ovf_q        <= ovf_d;
      seg_q        <= seg_d;
    end
  end

  assign {sw.seg_m10, sw.seg_m1, sw.seg_s10, sw.seg_s1, sw.seg_c10, sw.seg_c1} = seg_q;
  assign sw.running    = counting;
  assign sw.lap_active = (state_q == ST_LAP);
  assign sw.ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb/tb_stopwatch_lap.sv - directed bench for stopwatch_lap
module tb_stopwatch_lap;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  stopwatch_lap_if sif ();

  stopwatch_lap #(
    .CLK_HZ(1000), .TICK_HZ(100), .QUICK_MULT(5), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sif)
  );

  always #5 clk = ~clk;

  logic [41:0] seg_all;
  assign seg_all = {sif.seg_m10, sif.seg_m1, sif.seg_s10, sif.seg_s1, sif.seg_c10, sif.seg_c1};

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] exp_seg(input logic [23:0] b);
    return {pat(b[23:20]), pat(b[19:16]), pat(b[15:12]), pat(b[11:8]), pat(b[7:4]), pat(b[3:0])};
  endfunction

  // Input rises for 3 edges (state changes on the 3rd), then low for 3 edges.
  task automatic press(input logic do_ss, input logic do_lap);
    sif.start_stop = do_ss;
    sif.lap        = do_lap;
    repeat (3) @(negedge clk);
    sif.start_stop = 1'b0;
    sif.lap        = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.start_stop = 1'b0; sif.lap = 1'b0; sif.quick = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (seg_all !== exp_seg(24'h000000)) begin failed++; $display("FAIL reset_seg: got %h expected %h", seg_all, exp_seg(24'h000000)); end
    tests++; if ({sif.running, sif.lap_active, sif.ovf} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b expected 000", {sif.running, sif.lap_active, sif.ovf}); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (seg_all !== exp_seg(24'h000000) || sif.running !== 1'b0) begin failed++; $display("FAIL reset_release: got %h/%b expected %h/0", seg_all, sif.running, exp_seg(24'h000000)); end
  endtask

  task automatic test_start_stop();
    press(1'b1, 1'b0);                 // RUN at edge E, now after E+3
    tests++; if (sif.running !== 1'b1) begin failed++; $display("FAIL start_running: got %b expected 1", sif.running); end
    repeat (994) @(negedge clk);
    press(1'b1, 1'b0);                 // STOP at E+1000, 100 ticks counted
    tests++; if (seg_all !== exp_seg(24'h000100)) begin failed++; $display("FAIL stop_display: got %h expected %h", seg_all, exp_seg(24'h000100)); end
    tests++; if (sif.running !== 1'b0) begin failed++; $display("FAIL stop_running: got %b expected 0", sif.running); end
    press(1'b1, 1'b0);                 // RUN at R, divider resumes from 0
    repeat (99) @(negedge clk);
    press(1'b1, 1'b0);                 // STOP at R+105: ticks at R+10..R+100
    tests++; if (seg_all !== exp_seg(24'h000110)) begin failed++; $display("FAIL resume_display: got %h expected %h", seg_all, exp_seg(24'h000110)); end
  endtask

  // Starts in STOP with the divider at 5: one tick 5 edges after resuming.
  task automatic test_carry(input logic [23:0] preload, input logic [23:0] expect_cnt);
    force dut.cnt_q = preload;
    @(negedge clk);
    release dut.cnt_q;
    press(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    tests++; if (seg_all !== exp_seg(expect_cnt)) begin failed++; $display("FAIL carry_%h: got %h expected %h", preload, seg_all, exp_seg(expect_cnt)); end
    press(1'b1, 1'b0);
    tests++; if (sif.running !== 1'b0 || seg_all !== exp_seg(expect_cnt)) begin failed++; $display("FAIL carry_stop_%h: got %b/%h expected 0/%h", preload, sif.running, seg_all, exp_seg(expect_cnt)); end
  endtask

  task automatic test_clear();
    press(1'b0, 1'b1);
    tests++; if (seg_all !== exp_seg(24'h000000)) begin failed++; $display("FAIL clear_display: got %h expected %h", seg_all, exp_seg(24'h000000)); end
    tests++; if (dut.state_q !== 2'd0 || sif.running !== 1'b0) begin failed++; $display("FAIL clear_state: got %0d/%b expected 0/0", dut.state_q, sif.running); end
  endtask

  task automatic test_lap();
    press(1'b1, 1'b0);                 // RUN at E, divider 0
    repeat (299) @(negedge clk);
    press(1'b0, 1'b1);                 // LAP at E+305, split 00:00.30
    repeat (197) @(negedge clk);       // now after E+505
    tests++; if (seg_all !== exp_seg(24'h000030)) begin failed++; $display("FAIL lap_frozen: got %h expected %h", seg_all, exp_seg(24'h000030)); end
    tests++; if (dut.cnt_q !== 24'h000050) begin failed++; $display("FAIL lap_internal: got %h expected 000050", dut.cnt_q); end
    tests++; if (sif.lap_active !== 1'b1 || sif.running !== 1'b1) begin failed++; $display("FAIL lap_flags: got %b%b expected 11", sif.lap_active, sif.running); end
    press(1'b0, 1'b1);                 // RUN at E+508, tick at E+510
    tests++; if (seg_all !== exp_seg(24'h000051)) begin failed++; $display("FAIL lap_live: got %h expected %h", seg_all, exp_seg(24'h000051)); end
    tests++; if (sif.lap_active !== 1'b0) begin failed++; $display("FAIL lap_release: got %b expected 0", sif.lap_active); end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);                 // STOP at E+514
    tests++; if (sif.running !== 1'b0 || sif.lap_active !== 1'b0) begin failed++; $display("FAIL simul_state: got %b%b expected 00", sif.running, sif.lap_active); end
    tests++; if (dut.split_q !== 24'h000030) begin failed++; $display("FAIL simul_split: got %h expected 000030", dut.split_q); end
    tests++; if (seg_all !== exp_seg(24'h000051)) begin failed++; $display("FAIL simul_display: got %h expected %h", seg_all, exp_seg(24'h000051)); end
  endtask

  task automatic test_overflow();
    press(1'b0, 1'b1);                 // back to IDLE
    sif.quick = 1'b1;
    repeat (3) @(negedge clk);
    force dut.cnt_q = 24'h995998;
    @(negedge clk);
    release dut.cnt_q;
    press(1'b1, 1'b0);                 // RUN at E, ticks at E+2, E+4
    tests++; if (dut.cnt_q !== 24'h995999 || sif.running !== 1'b1 || sif.ovf !== 1'b0) begin failed++; $display("FAIL ovf_pre: got %h/%b/%b expected 995999/1/0", dut.cnt_q, sif.running, sif.ovf); end
    repeat (3) @(negedge clk);
    tests++; if (seg_all !== exp_seg(24'h995999)) begin failed++; $display("FAIL ovf_hold: got %h expected %h", seg_all, exp_seg(24'h995999)); end
    tests++; if (sif.ovf !== 1'b1 || sif.running !== 1'b0) begin failed++; $display("FAIL ovf_flags: got %b/%b expected 1/0", sif.ovf, sif.running); end
    press(1'b1, 1'b0);
    tests++; if (sif.ovf !== 1'b1 || sif.running !== 1'b0 || seg_all !== exp_seg(24'h995999)) begin failed++; $display("FAIL ovf_ss_ignored: got %b/%b/%h expected 1/0/%h", sif.ovf, sif.running, seg_all, exp_seg(24'h995999)); end
    press(1'b0, 1'b1);
    tests++; if (sif.ovf !== 1'b0 || seg_all !== exp_seg(24'h000000)) begin failed++; $display("FAIL ovf_clear: got %b/%h expected 0/%h", sif.ovf, seg_all, exp_seg(24'h000000)); end
  endtask

  task automatic test_quick_toggle();
    sif.quick = 1'b0;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0);                 // RUN at E, now after E+3
    repeat (2) @(negedge clk);
    sif.quick = 1'b1;                  // synchronised level valid after E+7 (divider 7)
    repeat (2) @(negedge clk);
    tests++; if (dut.cnt_q !== 24'h000000) begin failed++; $display("FAIL quick_before: got %h expected 000000", dut.cnt_q); end
    @(negedge clk);
    tests++; if (dut.cnt_q !== 24'h000001) begin failed++; $display("FAIL quick_tick: got %h expected 000001", dut.cnt_q); end
    repeat (2) @(negedge clk);
    tests++; if (dut.cnt_q !== 24'h000002) begin failed++; $display("FAIL quick_rate: got %h expected 000002", dut.cnt_q); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    tests++; if (seg_all !== exp_seg(24'h000000)) begin failed++; $display("FAIL areset_seg: got %h expected %h", seg_all, exp_seg(24'h000000)); end
    tests++; if ({sif.running, sif.lap_active, sif.ovf} !== 3'b000 || dut.cnt_q !== 24'h000000) begin failed++; $display("FAIL areset_state: got %b/%h expected 000/000000", {sif.running, sif.lap_active, sif.ovf}, dut.cnt_q); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (dut.state_q !== 2'd0 || dut.cnt_q !== 24'h000000) begin failed++; $display("FAIL areset_idle: got %0d/%h expected 0/000000", dut.state_q, dut.cnt_q); end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_carry(24'h005999, 24'h010000);
    test_carry(24'h095999, 24'h100000);
    test_clear();
    test_lap();
    test_simultaneous();
    test_overflow();
    test_quick_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
